i2c_slave_burst: RTL

Parametrised I2C target with multi-byte burst read/write, repeated-START support, general STOP/START abort from any state, and auto-incrementing register offset. It is the next-generation successor to the single-byte I2C slave. It sits between the board-level SCL/SDA pins and a local register file, issuing one-cycle write and read strobes per data byte.

---
 rtl/i2c_pkg.sv | 10 +
 rtl/i2c_line_sync.sv | 36 +++
 rtl/i2c_slave_burst.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state encoding and bus constants for the burst I2C target
package i2c_pkg;
  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, OFFSET, OFFSET_ACK, WDATA, WDATA_ACK, RLOAD, RDATA, RDATA_ACK, IGNORE
  } i2c_state_t;
  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ = 1'b1;
  localparam logic ACK = 1'b0;
  localparam logic NACK = 1'b1;
endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: synchronises scl_i/sda_i and emits sda_o plus scl_rise_o, scl_fall_o, start_o, stop_o pulses
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);
  logic [SYNC_STAGES-1:0] scl_q, sda_q;
  logic scl_p_q, sda_p_q;
  logic scl_s;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      scl_q <= '1;
      sda_q <= '1;
      scl_p_q <= 1'b1;
      sda_p_q <= 1'b1;
    end else begin
      scl_q <= {scl_q[SYNC_STAGES-2:0], scl_i};
      sda_q <= {sda_q[SYNC_STAGES-2:0], sda_i};
      scl_p_q <= scl_q[SYNC_STAGES-1];
      sda_p_q <= sda_q[SYNC_STAGES-1];
    end
  assign scl_s = scl_q[SYNC_STAGES-1];
  assign sda_o = sda_q[SYNC_STAGES-1];
  assign scl_rise_o = scl_s && !scl_p_q;
  assign scl_fall_o = !scl_s && scl_p_q;
  assign start_o = scl_s && scl_p_q && sda_p_q && !sda_o;
  assign stop_o = scl_s && scl_p_q && !sda_p_q && sda_o;
endmodule

// File: rtl/i2c_slave_burst.sv
// i2c_slave_burst: I2C target with burst read/write and auto-increment offset; pins scl/sda, register side o_wr_en/o_rd_en/o_reg_addr/o_wr_data/i_rd_data, o_busy
module i2c_slave_burst
  import i2c_pkg::*;
#(
  parameter int OFFSET_BYTES = 1,
  parameter int SYNC_STAGES = 2,
  parameter bit AUTO_INC = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      scl,
  inout  wire                       sda,
  input  logic [6:0]                i_slave_addr,
  input  logic [7:0]                i_rd_data,
  output logic                      o_wr_en,
  output logic                      o_rd_en,
  output logic [8*OFFSET_BYTES-1:0] o_reg_addr,
  output logic [7:0]                o_wr_data,
  output logic                      o_busy
);
  localparam int OW = 8*OFFSET_BYTES;
  i2c_state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d, wd_q, wd_d;
  logic [OW-1:0] off_q, off_d, addr_q, addr_d;
  logic wr_q, wr_d, rd_q, rd_d, oe_q, oe_d, rw_q, rw_d, ob_q, ob_d;
  logic sda_s, scl_rise, scl_fall, start, stop;
  logic [7:0] byte_in;
  logic last_bit, last_off;
  logic [OW-1:0] inc;
  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk), .rst(rst), .scl_i(scl), .sda_i(sda), .sda_o(sda_s),
    .scl_rise_o(scl_rise), .scl_fall_o(scl_fall), .start_o(start), .stop_o(stop)
  );
  assign byte_in = {sh_q[6:0], sda_s};
  assign last_bit = cnt_q == 3'd7;
  assign last_off = ob_q == 1'(OFFSET_BYTES-1);
  assign inc = OW'(AUTO_INC);
  // ACK states toggle oe on each SCL fall: first fall drives the ACK, second releases it and moves on
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    sh_d = sh_q;
    off_d = off_q;
    addr_d = addr_q;
    wd_d = wd_q;
    wr_d = 1'b0;
    rd_d = 1'b0;
    oe_d = oe_q;
    rw_d = rw_q;
    ob_d = ob_q;
    if (start) begin
      state_d = ADDR;
      cnt_d = '0;
      oe_d = 1'b0;
    end else if (stop) begin
      state_d = IDLE;
      oe_d = 1'b0;
    end else begin
      case (state_q)
        ADDR: if (scl_rise) begin
          sh_d = byte_in;
          cnt_d = cnt_q + 3'd1;
          if (last_bit) begin
            rw_d = sda_s;
            ob_d = 1'b0;
            state_d = sh_q[6:0] == i_slave_addr ? ADDR_ACK : IGNORE;
          end
        end
        ADDR_ACK: if (scl_fall) begin
          oe_d = !oe_q;
          if (oe_q) begin
            state_d = rw_q == I2C_RW_READ ? RLOAD : OFFSET;
            rd_d = rw_q == I2C_RW_READ;
          end
        end
        OFFSET: if (scl_rise) begin
          sh_d = byte_in;
          cnt_d = cnt_q + 3'd1;
          if (last_bit) begin
            off_d = OW'({off_q, byte_in});
            state_d = OFFSET_ACK;
          end
        end
        OFFSET_ACK: if (scl_fall) begin
          oe_d = !oe_q;
          if (oe_q) begin
            ob_d = !ob_q;
            state_d = last_off ? WDATA : OFFSET;
            addr_d = last_off ? off_q : addr_q;
          end
        end
        WDATA: if (scl_rise) begin
          sh_d = byte_in;
          cnt_d = cnt_q + 3'd1;
          state_d = last_bit ? WDATA_ACK : WDATA;
        end
        WDATA_ACK: if (scl_fall) begin
          oe_d = !oe_q;
          wr_d = !oe_q;
          wd_d = oe_q ? wd_q : sh_q;
          if (oe_q) begin
            addr_d = addr_q + inc;
            state_d = WDATA;
          end
        end
        // rd_q is high the first RLOAD cycle; the byte is taken one cycle later
        RLOAD: if (!rd_q) begin
          sh_d = i_rd_data;
          oe_d = !i_rd_data[7];
          state_d = RDATA;
        end
        RDATA: if (scl_fall) begin
          cnt_d = cnt_q + 3'd1;
          sh_d = {sh_q[6:0], 1'b0};
          oe_d = !last_bit && !sh_q[6];
          state_d = last_bit ? RDATA_ACK : RDATA;
        end
        RDATA_ACK: if (scl_rise) begin
          state_d = sda_s == NACK ? IGNORE : RDATA_ACK;
          addr_d = sda_s == NACK ? addr_q : addr_q + inc;
        end else if (scl_fall) begin
          state_d = RLOAD;
          rd_d = 1'b1;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      sh_q <= '0;
      off_q <= '0;
      addr_q <= '0;
      wd_q <= '0;
      wr_q <= 1'b0;
      rd_q <= 1'b0;
      oe_q <= 1'b0;
      rw_q <= I2C_RW_WRITE;
      ob_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sh_q <= sh_d;
      off_q <= off_d;
      addr_q <= addr_d;
      wd_q <= wd_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      oe_q <= oe_d;
      rw_q <= rw_d;
      ob_q <= ob_d;
    end
  assign sda = oe_q ? 1'b0 : 1'bz;
  assign o_wr_en = wr_q;
  assign o_rd_en = rd_q;
  assign o_reg_addr = addr_q;
  assign o_wr_data = wd_q;
  assign o_busy = !(state_q inside {IDLE, ADDR, IGNORE});
endmodule
